// File: rtl/fir_output_stage.sv
// fir_output_stage
//   Final stage of the FIR datapath. It takes the full-precision accumulated sum
//   from the delay chain, rounds away SHIFT fractional bits (half toward +inf),
//   saturates to an M-bit signed word and queues the result in a DEPTH-entry
//   FIFO. The FIFO drains over a valid/ready handshake, so the filter core never
//   has to stall.
//
//   Ports
//     clk        single clock, all state updates on the rising edge
//     rst        asynchronous active-high reset
//     ena        sample strobe shared with the delay chain; y_in valid when high
//     y_in       N-bit signed accumulated sum
//     q_out      M-bit signed sample at the FIFO head
//     q_valid    FIFO non-empty, q_out holds a real sample
//     q_ready    consumer takes the head when q_valid is also high
//     count      FIFO occupancy, 0..DEPTH
//     sat_flag   sticky, some sample had to be clamped
//     drop_flag  sticky, some sample was lost because the FIFO was full
module fir_output_stage #(
    parameter int N     = 32,
    parameter int M     = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [N-1:0]             y_in,
    output logic [M-1:0]             q_out,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sat_flag,
    output logic                     drop_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = N + 1 - SHIFT;
    localparam logic signed [N:0]    HALF = (N+1)'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0] MAXV = {{(RW-M+1){1'b0}}, {(M-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-M+1){1'b1}}, {(M-1){1'b0}}};
    localparam logic [AW:0]          FULL = (AW+1)'(DEPTH);

    logic signed [N:0]    rsum;
    logic                 unused_rsum_frac;
    logic signed [RW-1:0] r;
    logic                 v1;
    logic [M-1:0]         sample;
    logic                 sat_now;
    logic [M-1:0]         mem [DEPTH];
    logic [AW-1:0]        wrptr;
    logic [AW-1:0]        rdptr;
    logic [M-1:0]         last_q;
    logic                 push;
    logic                 pop;

    // The sum is widened by one bit before adding the half-LSB so that the
    // largest positive input cannot wrap. Keeping only the bits above SHIFT is
    // the arithmetic right shift; the fractional bits are simply discarded.
    assign rsum             = $signed({y_in[N-1], y_in}) + HALF;
    assign unused_rsum_frac = ^rsum[SHIFT-1:0];

    // Stage 1: rounding register. The valid bit follows ena on every edge so a
    // gap in the strobe becomes a bubble, while the data only moves when ena is
    // high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r  <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= ena;
            if (ena)
                r <= rsum[N:SHIFT];
        end
    end

    // Stage 2: clamp the rounded value into the M-bit signed range. The
    // rounded value is a few bits wider than the output word, so both ends
    // can overflow.
    always_comb begin
        sample  = r[M-1:0];
        sat_now = 1'b0;
        if (r > MAXV) begin
            sample  = {1'b0, {(M-1){1'b1}}};
            sat_now = 1'b1;
        end else if (r < MINV) begin
            sample  = {1'b1, {(M-1){1'b0}}};
            sat_now = 1'b1;
        end
    end

    // A pop frees a slot on the same edge, so a full FIFO can still take a
    // new sample when the consumer is reading.
    assign q_valid = (count != '0);
    assign pop     = q_valid & q_ready;
    assign push    = v1 & ((count < FULL) | pop);

    // FIFO storage has no reset; entries are only ever read once the
    // occupancy counter says they were written.
    always_ff @(posedge clk) begin
        if (push)
            mem[wrptr] <= sample;
    end

    // FIFO control and sticky status. Pointers wrap naturally because DEPTH
    // is a power of two. last_q remembers the most recently popped head so
    // q_out holds steady when the FIFO runs dry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrptr     <= '0;
            rdptr     <= '0;
            count     <= '0;
            last_q    <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (push)
                wrptr <= wrptr + 1'b1;
            if (pop) begin
                rdptr  <= rdptr + 1'b1;
                last_q <= mem[rdptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (v1 && sat_now)
                sat_flag <= 1'b1;
            if (v1 && !push)
                drop_flag <= 1'b1;
        end
    end

    // Head entry drives the output while valid; otherwise the last head value
    // is held, which is also zero straight out of reset.
    assign q_out = q_valid ? mem[rdptr] : last_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage
//   Directed bench for fir_output_stage at its default parameters
//   (N=32, M=16, SHIFT=15, DEPTH=4). Inputs change 1 time unit after the
//   rising edge and outputs are sampled there too, away from the edge.
module tb_fir_output_stage;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [31:0] y_in;
    logic [15:0] q_out;
    logic        q_valid;
    logic        q_ready;
    logic [2:0]  count;
    logic        sat_flag;
    logic        drop_flag;

    int checks   = 0;
    int failures = 0;

    fir_output_stage #(
        .N(32), .M(16), .SHIFT(15), .DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .y_in      (y_in),
        .q_out     (q_out),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .count     (count),
        .sat_flag  (sat_flag),
        .drop_flag (drop_flag)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] yv, input logic e, input logic rdy);
        y_in    = yv;
        ena     = e;
        q_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One isolated sample through the two-stage path with q_ready high; the
    // sample gets popped on the first edge of the following call.
    task automatic roundCase(input string tag, input logic [31:0] yv, input logic [15:0] expq);
        applyStimulus(yv, 1'b1, 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1);
        tick();
        checkOutput({tag, "_valid"}, 32'(q_valid), 32'd1);
        checkOutput(tag, 32'(q_out), 32'(expq));
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [15:0] expq[$];
    logic [15:0] head;
    int          nextv;
    int          sent;
    int          recv;
    int          v;
    logic        e;
    logic        rdy;

    initial begin
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("rst_q_out", 32'(q_out), 32'd0);
        checkOutput("rst_q_valid", 32'(q_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_sat", 32'(sat_flag), 32'd0);
        checkOutput("rst_drop", 32'(drop_flag), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] async reset with three entries queued");
        applyStimulus(32'd7 << 15, 1'b1, 1'b0);
        tick();
        applyStimulus(32'd8 << 15, 1'b1, 1'b0);
        tick();
        applyStimulus(32'd9 << 15, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        checkOutput("pre_rst_head", 32'(q_out), 32'd7);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_q_out", 32'(q_out), 32'd0);
        checkOutput("mid_rst_q_valid", 32'(q_valid), 32'd0);
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_count", 32'(count), 32'd0);
        checkOutput("post_rst_q_valid", 32'(q_valid), 32'd0);

        $display("[TB] rounding");
        roundCase("round_3fff", 32'h0000_3FFF, 16'h0000);
        roundCase("round_4000", 32'h0000_4000, 16'h0001);
        roundCase("round_8000", 32'h0000_8000, 16'h0001);
        roundCase("round_m16384", 32'hFFFF_C000, 16'h0000);
        roundCase("round_m16385", 32'hFFFF_BFFF, 16'hFFFF);
        tick();
        checkOutput("round_no_sat", 32'(sat_flag), 32'd0);

        $display("[TB] saturation");
        applyStimulus(32'h7FFF_FFFF, 1'b1, 1'b1);
        tick();
        checkOutput("sat_not_yet", 32'(sat_flag), 32'd0);
        applyStimulus(32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("sat_flag_set", 32'(sat_flag), 32'd1);
        checkOutput("sat_pos", 32'(q_out), 32'h7FFF);
        roundCase("sat_neg", 32'h8000_0000, 16'h8000);
        tick();
        checkOutput("sat_sticky", 32'(sat_flag), 32'd1);
        pulseReset();
        checkOutput("sat_cleared", 32'(sat_flag), 32'd0);

        $display("[TB] full plus simultaneous pop");
        for (int k = 10; k <= 14; k++) begin
            applyStimulus(32'(k) << 15, 1'b1, 1'b0);
            tick();
        end
        checkOutput("fp_full", 32'(count), 32'd4);
        nextv = 10;
        for (int k = 15; k <= 24; k++) begin
            applyStimulus(32'(k) << 15, 1'b1, 1'b1);
            checkOutput("fp_order", 32'(q_out), 32'(nextv));
            nextv++;
            tick();
            checkOutput("fp_count", 32'(count), 32'd4);
        end
        checkOutput("fp_no_drop", 32'(drop_flag), 32'd0);
        applyStimulus(32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && nextv < 25; i++) begin
            if (q_valid) begin
                checkOutput("fp_drain_order", 32'(q_out), 32'(nextv));
                nextv++;
            end
            tick();
        end
        checkOutput("fp_drain_all", 32'(nextv), 32'd25);
        checkOutput("fp_drain_count", 32'(count), 32'd0);

        $display("[TB] full and drop");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(32'(k) << 15, 1'b1, 1'b0);
            tick();
        end
        checkOutput("fd_count4", 32'(count), 32'd4);
        checkOutput("fd_drop_not_yet", 32'(drop_flag), 32'd0);
        applyStimulus(32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("fd_drop_set", 32'(drop_flag), 32'd1);
        checkOutput("fd_count_held", 32'(count), 32'd4);
        applyStimulus(32'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("fd_out", 32'(q_out), 32'(k));
            tick();
        end
        checkOutput("fd_empty_count", 32'(count), 32'd0);
        checkOutput("fd_empty_valid", 32'(q_valid), 32'd0);
        checkOutput("fd_hold_last", 32'(q_out), 32'd4);
        checkOutput("fd_drop_sticky", 32'(drop_flag), 32'd1);
        pulseReset();

        $display("[TB] pointer wrap with random q_ready");
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            e   = (sent < 20) && (count <= 3'd2) && ($urandom_range(0, 1) == 1);
            v   = ((sent * 1237 + 5) % 32768) - 16384;
            applyStimulus(32'(v * 32768), e, rdy);
            if (e) begin
                expq.push_back(16'(v));
                sent++;
            end
            if (q_valid && rdy) begin
                checkOutput("wrap_expected_pending", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    head = expq.pop_front();
                    checkOutput("wrap_order", 32'(q_out), 32'(head));
                end
                recv++;
            end
            tick();
        end
        checkOutput("wrap_sent", 32'(sent), 32'd20);
        checkOutput("wrap_recv", 32'(recv), 32'd20);
        checkOutput("wrap_no_drop", 32'(drop_flag), 32'd0);
        checkOutput("wrap_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
